note_judge: RTL

- Reads one falling-note lane and the player's key, then judges each note as perfect (score), near, or miss.
- Sits beside the lane shifter. It consumes the lane's per-slot occupancy and shift tick, and drives the judgment pulses plus running combo and points to the HEX/score logic.
- One instance per lane.

---
 rtl/note_judge.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/note_judge.sv
// Per-lane note judge: synchronizes and debounces the lane key, grades each press
// against the lane's target/approach slots, and keeps the saturating combo and points totals.
module note_judge #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned PTS_PERFECT = 2,
  parameter int unsigned PTS_NEAR    = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       KEY,
  input  logic       enable,
  input  logic       shift_tick,
  input  logic [7:0] lane_occ,
  output logic       score,
  output logic       near,
  output logic       miss,
  output logic [7:0] combo,
  output logic [9:0] points
);

  localparam logic [7:0]  DEB    = 8'(DEB_CYCLES);
  localparam logic [10:0] P_PERF = 11'(PTS_PERFECT);
  localparam logic [10:0] P_NEAR = 11'(PTS_NEAR);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HELD, S_REL} deb_state_t;

  deb_state_t  r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        r_sync1, r_sync2, w_ks;
  logic [1:0]  r_warm;
  logic        r_rel_seen;
  logic        w_press_evt;
  logic        r_j0, r_j1;
  logic        w_press, w_perf, w_near, w_miss;
  logic        r_score, r_near, r_miss;
  logic [7:0]  r_combo;
  logic [9:0]  r_points;
  logic [10:0] w_sum;
  logic        w_unused;

  assign w_unused = ^lane_occ[7:2];
  assign w_ks      = r_sync2;
  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  // The synchronizer resets to "released", so a key still held through reset would
  // look like a fresh press; arming waits for a genuine released sample first.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_warm     <= '0;
      r_rel_seen <= 1'b0;
    end else begin
      r_warm     <= {r_warm[0], 1'b1};
      r_rel_seen <= r_rel_seen | (r_warm[1] & w_ks);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_evt = 1'b0;
    case (r_state)
      S_IDLE: if (!w_ks && r_rel_seen) begin
        w_state_nxt = S_ARM;
        w_cnt_nxt   = 8'd1;
      end
      S_ARM: begin
        if (w_ks) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= DEB) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
          w_press_evt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_HELD: if (w_ks) begin
        w_state_nxt = S_REL;
        w_cnt_nxt   = 8'd1;
      end
      S_REL: begin
        if (!w_ks) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= DEB) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Judgment uses pre-shift occupancy; a perfect on the exiting note cancels its miss.
  assign w_press = w_press_evt & enable;
  assign w_perf  = w_press & lane_occ[0] & ~r_j0;
  assign w_near  = w_press & ~w_perf & lane_occ[1] & ~r_j1;
  assign w_miss  = enable & shift_tick & lane_occ[0] & ~r_j0 & ~w_perf;
  assign w_sum   = {1'b0, r_points} + (w_perf ? P_PERF : P_NEAR);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_j0 <= 1'b0;
      r_j1 <= 1'b0;
    end else if (!enable) begin
      r_j0 <= 1'b0;
      r_j1 <= 1'b0;
    end else if (shift_tick) begin
      r_j0 <= r_j1 | w_near;
      r_j1 <= 1'b0;
    end else begin
      if (w_perf) r_j0 <= 1'b1;
      if (w_near) r_j1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_score  <= 1'b0;
      r_near   <= 1'b0;
      r_miss   <= 1'b0;
      r_combo  <= '0;
      r_points <= '0;
    end else begin
      r_score <= w_perf;
      r_near  <= w_near;
      r_miss  <= w_miss;
      if (w_miss) begin
        r_combo <= '0;
      end else if (w_perf || w_near) begin
        if (r_combo != 8'hFF) r_combo <= r_combo + 8'd1;
        r_points <= (w_sum > 11'd1023) ? 10'd1023 : w_sum[9:0];
      end
    end
  end

  assign score  = r_score;
  assign near   = r_near;
  assign miss   = r_miss;
  assign combo  = r_combo;
  assign points = r_points;

endmodule
